mult_product_accumulator: RTL and testbench
===========================================

MULT_PRODUCT_ACCUMULATOR -- requirements
Module: mult_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 12, sets the accumulator and result width in bits; legal range 8..32.
REQ-002 Parameter FRAME_LEN, default 4, sets the number of products summed per frame; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 p_in  input  8  unsigned product from the upstream 4x4 add-shift multiplier.
REQ-006 p_valid  input  1  p_in holds a valid product.
REQ-007 p_ready  output  1  block can accept a product this cycle.
REQ-008 acc_out  output  ACC_W  frame sum, registered.
REQ-009 acc_valid  output  1  acc_out holds a complete frame sum.
REQ-010 acc_ready  input  1  downstream accepts acc_out.
REQ-011 ovf  output  1  sticky flag: an addition in the current frame exceeded 2^ACC_W-1.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-014 A product transfer SHALL occur on a rising edge where p_valid=1 and p_ready=1.
REQ-015 p_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-016 On each transfer, the block SHALL add p_in, zero-extended to ACC_W+1 bits, to the sum and SHALL increment a 4-bit frame counter.
REQ-017 Transitions SHALL be: IDLE->ACCUM on the first transfer; ACCUM->DONE on the FRAME_LEN-th transfer; DONE->IDLE on acc_valid&&acc_ready.
REQ-018 With FRAME_LEN=1, IDLE SHALL go directly to DONE on the single transfer.
REQ-019 acc_valid SHALL assert in the cycle after the final transfer, giving a latency of 1 cycle from the last product to the result.
REQ-020 acc_out and ovf SHALL remain stable while acc_valid=1 and acc_ready=0.
REQ-021 On the DONE->IDLE edge, the block SHALL clear the sum, counter and ovf to 0, deassert acc_valid, and accept no product in that cycle.
REQ-022 Cycles with p_valid=0 in ACCUM SHALL leave all state unchanged; gaps between products are unlimited.
REQ-023 A carry out of bit ACC_W-1 SHALL set ovf; ovf SHALL stay set until the frame is consumed or rst is asserted.
REQ-024 acc_valid SHALL assert only in DONE; the output handshake is valid/ready and acc_valid SHALL NOT drop without acc_ready.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL enter IDLE and clear the sum, counter, acc_out, acc_valid and ovf to 0.
REQ-026 Reset outputs SHALL be p_ready=1 and busy=0.
REQ-027 rst SHALL take priority over any simultaneous transfer or output handshake.
REQ-028 A reset asserted mid-frame or in DONE SHALL discard the partial or pending sum.

Configuration
REQ-029 The macro ACC_SATURATE_EN SHALL select the overflow behaviour.
REQ-030 When ACC_SATURATE_EN is defined, an overflowing addition SHALL clamp the sum to 2^ACC_W-1, and later additions in the frame SHALL keep it clamped.
REQ-031 When ACC_SATURATE_EN is undefined, the sum SHALL wrap modulo 2^ACC_W.
REQ-032 ovf behaviour SHALL be identical in both builds.

Verification
REQ-033 Basic frame: defaults, products 15,30,45,225 back-to-back, acc_ready=1 -> acc_out=315, ovf=0, acc_valid high exactly 1 cycle after the 4th transfer.
REQ-034 Back-pressure: same frame, acc_ready=0 for 3 cycles, then 1 -> acc_out=315 held, p_ready=0 throughout, and p_valid=1 with p_in=7 is not accepted until the cycle after the handshake.
REQ-035 Overflow: ACC_W=8, FRAME_LEN=2, products 200,100 -> acc_out=44, ovf=1 without the macro; acc_out=255, ovf=1 with ACC_SATURATE_EN.
REQ-036 Reset mid-frame: products 10,20, rst for 1 cycle, then 1,2,3,4 -> acc_out=10, ovf=0.
REQ-037 Gaps and FRAME_LEN=1: with defaults, products 5 then idle for 4 cycles, then 6,7,8 -> acc_out=26; with FRAME_LEN=1, product 9 -> acc_out=9 one cycle later, then IDLE after the handshake.

Source files
------------

// File: rtl/mult_product_accumulator.sv
// Frame accumulator: sums FRAME_LEN unsigned 8-bit products, then holds the result on a valid/ready port.
// Define ACC_SATURATE_EN to clamp overflowing sums at 2^ACC_W-1 instead of wrapping.
module mult_product_accumulator #(
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     wide;

  function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] s,
                                               input logic [7:0] p);
    return {1'b0, s} + {{(ACC_W-7){1'b0}}, p};
  endfunction

  // The carry bit of the widened sum decides between clamp and wrap.
  function automatic logic [ACC_W-1:0] sat_or_wrap(input logic [ACC_W:0] w);
    logic [ACC_W-1:0] r;
    r = w[ACC_W-1:0];
    if (SAT && w[ACC_W]) r = '1;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wide    = add_wide(sum_q, p_in);
    case (state_q)
      IDLE, ACCUM: begin
        if (p_valid) begin
          sum_d = sat_or_wrap(wide);
          ovf_d = ovf_q | wide[ACC_W];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            acc_d   = sat_or_wrap(wide);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (acc_ready) begin
          state_d = IDLE;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p_ready   = (state_q != DONE);
  assign acc_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: three instances (defaults, ACC_W=8/FRAME_LEN=2, FRAME_LEN=1)
// checked every cycle against a frame-level model, plus literal expectations.
module tb_mult_product_accumulator;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_s [3];
  logic [7:0]  pin   [3];
  logic        pv    [3];
  logic        ar    [3];
  logic        prdy  [3];
  logic        av    [3];
  logic        ov    [3];
  logic        bz    [3];
  logic [11:0] ao0, ao2;
  logic [7:0]  ao1;
  logic [31:0] ao    [3];

  assign ao[0] = {20'd0, ao0};
  assign ao[1] = {24'd0, ao1};
  assign ao[2] = {20'd0, ao2};

  always #5 clk = ~clk;

  mult_product_accumulator #(.ACC_W(12), .FRAME_LEN(4)) u0 (
    .clk(clk), .rst(rst_s[0]), .p_in(pin[0]), .p_valid(pv[0]), .p_ready(prdy[0]),
    .acc_out(ao0), .acc_valid(av[0]), .acc_ready(ar[0]), .ovf(ov[0]), .busy(bz[0]));
  mult_product_accumulator #(.ACC_W(8), .FRAME_LEN(2)) u1 (
    .clk(clk), .rst(rst_s[1]), .p_in(pin[1]), .p_valid(pv[1]), .p_ready(prdy[1]),
    .acc_out(ao1), .acc_valid(av[1]), .acc_ready(ar[1]), .ovf(ov[1]), .busy(bz[1]));
  mult_product_accumulator #(.ACC_W(12), .FRAME_LEN(1)) u2 (
    .clk(clk), .rst(rst_s[2]), .p_in(pin[2]), .p_valid(pv[2]), .p_ready(prdy[2]),
    .acc_out(ao2), .acc_valid(av[2]), .acc_ready(ar[2]), .ovf(ov[2]), .busy(bz[2]));

  int n_chk = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: count of products taken, running result, pending result, sticky overflow.
  int W [3] = '{12, 8, 12};
  int L [3] = '{4, 2, 1};
  int m_cnt [3];
  int m_acc [3];
  bit m_pend [3];
  bit m_ovf [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int mx;
      mx = (1 << W[k]) - 1;
      if (rst_s[k]) begin
        m_cnt[k] = 0; m_acc[k] = 0; m_pend[k] = 0; m_ovf[k] = 0;
      end else if (m_pend[k]) begin
        if (ar[k]) begin
          m_cnt[k] = 0; m_acc[k] = 0; m_pend[k] = 0; m_ovf[k] = 0;
        end
      end else if (pv[k]) begin
        if (m_acc[k] + int'(pin[k]) > mx) begin
          m_ovf[k] = 1;
          m_acc[k] = SAT ? mx : m_acc[k] + int'(pin[k]) - (mx + 1);
        end else begin
          m_acc[k] = m_acc[k] + int'(pin[k]);
        end
        m_cnt[k]++;
        if (m_cnt[k] == L[k]) m_pend[k] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("p_ready[%0d]", k), int'(prdy[k]), int'(!m_pend[k]));
        chk($sformatf("acc_valid[%0d]", k), int'(av[k]), int'(m_pend[k]));
        chk($sformatf("busy[%0d]", k), int'(bz[k]), int'(m_pend[k] || m_cnt[k] > 0));
        chk($sformatf("ovf[%0d]", k), int'(ov[k]), int'(m_ovf[k]));
        if (m_pend[k]) chk($sformatf("acc_out[%0d]", k), int'(ao[k]), m_acc[k]);
      end
    end
  end

  task automatic cyc(input int k, input bit v, input int p, input bit r);
    pv[k] = v; pin[k] = 8'(p); ar[k] = r;
    @(posedge clk); #1;
  endtask

  task automatic rstc(input int k);
    rst_s[k] = 1'b1; pv[k] = 1'b0;
    @(posedge clk); #1;
    rst_s[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; pv[k] = 1'b0; ar[k] = 1'b1; pin[k] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    started = 1'b1;
    chk("rst p_ready", int'(prdy[0]), 1);
    chk("rst busy", int'(bz[0]), 0);
    chk("rst acc_valid", int'(av[0]), 0);
    chk("rst ovf", int'(ov[0]), 0);
    chk("rst acc_out", int'(ao[0]), 0);

    // Basic frame
    cyc(0, 1, 15, 1); cyc(0, 1, 30, 1); cyc(0, 1, 45, 1);
    chk("basic busy mid", int'(bz[0]), 1);
    chk("basic valid early", int'(av[0]), 0);
    cyc(0, 1, 225, 1);
    chk("basic valid", int'(av[0]), 1);
    chk("basic acc_out", int'(ao[0]), 315);
    chk("basic ovf", int'(ov[0]), 0);
    chk("basic p_ready", int'(prdy[0]), 0);
    cyc(0, 0, 0, 1);
    chk("basic valid after hs", int'(av[0]), 0);
    chk("basic idle after hs", int'(bz[0]), 0);

    // Back-pressure with a product waiting
    cyc(0, 1, 15, 0); cyc(0, 1, 30, 0); cyc(0, 1, 45, 0); cyc(0, 1, 225, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 7, 0);
      chk("bp acc_out held", int'(ao[0]), 315);
      chk("bp p_ready", int'(prdy[0]), 0);
      chk("bp valid held", int'(av[0]), 1);
    end
    cyc(0, 1, 7, 1);
    chk("bp no accept on hs", int'(bz[0]), 0);
    cyc(0, 1, 7, 1);
    chk("bp accept after hs", int'(bz[0]), 1);

    // Reset mid-frame, then reset while a result is pending
    rstc(0);
    chk("rst accum busy", int'(bz[0]), 0);
    cyc(0, 1, 10, 0); cyc(0, 1, 20, 0);
    rstc(0);
    cyc(0, 1, 1, 0); cyc(0, 1, 2, 0); cyc(0, 1, 3, 0); cyc(0, 1, 4, 0);
    chk("midrst acc_out", int'(ao[0]), 10);
    chk("midrst ovf", int'(ov[0]), 0);
    rstc(0);
    chk("rst done valid", int'(av[0]), 0);
    chk("rst done p_ready", int'(prdy[0]), 1);
    chk("rst done acc_out", int'(ao[0]), 0);

    // Gaps between products
    cyc(0, 1, 5, 1);
    repeat (4) cyc(0, 0, 0, 1);
    chk("gap busy", int'(bz[0]), 1);
    cyc(0, 1, 6, 1); cyc(0, 1, 7, 1); cyc(0, 1, 8, 1);
    chk("gap acc_out", int'(ao[0]), 26);
    cyc(0, 0, 0, 1);

    // Overflow, ACC_W=8 FRAME_LEN=2
    cyc(1, 1, 200, 1);
    chk("ovf not yet", int'(ov[1]), 0);
    cyc(1, 1, 100, 1);
    chk("ovf set", int'(ov[1]), 1);
    chk("ovf acc_out", int'(ao[1]), SAT ? 255 : 44);
    cyc(1, 0, 0, 1);
    chk("ovf cleared", int'(ov[1]), 0);
    cyc(1, 1, 100, 1); cyc(1, 1, 155, 1);
    chk("exact max acc_out", int'(ao[1]), 255);
    chk("exact max ovf", int'(ov[1]), 0);
    cyc(1, 0, 0, 1);

    // FRAME_LEN=1
    cyc(2, 1, 9, 0);
    chk("len1 valid", int'(av[2]), 1);
    chk("len1 acc_out", int'(ao[2]), 9);
    cyc(2, 0, 0, 0);
    chk("len1 held", int'(av[2]), 1);
    cyc(2, 0, 0, 1);
    chk("len1 idle", int'(bz[2]), 0);
    chk("len1 valid low", int'(av[2]), 0);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
